// File: rtl/ns_mode_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ns_ctrl_pkg
// Description : Shared types and constants for the noise-shaper mode
//               controller: feedback mode encoding, config bus addresses,
//               strobe divide ratio and the default HSNR gain helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ns_ctrl_pkg;

    // Feedback mode. The state bit doubles as the alpha output.
    typedef enum logic [0:0] {
        S_HSNR = 1'b0,
        S_HDR  = 1'b1
    } ns_mode_t;

    // Shadow register addresses on the config bus
    localparam logic CFG_GAIN_POS = 1'b0;
    localparam logic CFG_GAIN_NEG = 1'b1;

    // 24 MHz / 8 = 3 MHz sample strobe
    localparam int STROBE_DIV = 8;

    // Datapath widths
    localparam int DATA_W = 11;
    localparam int GAIN_W = 24;

    // Default positive gain: +2^bits
    function automatic logic signed [GAIN_W-1:0] default_gain_pos(input int bits);
        return $signed(GAIN_W'(1) << bits);
    endfunction

    // Default negative gain: -2^bits
    function automatic logic signed [GAIN_W-1:0] default_gain_neg(input int bits);
        return -default_gain_pos(bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ns_mode_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : ns_mode_controller_if
// Description : Register/config bus between the host and the mode controller.
//               master : bus side (drives writes and commit, reads pending)
//               slave  : controller side
//   cfg_we      - shadow register write strobe
//   cfg_addr    - 0 = positive gain, 1 = negative gain
//   cfg_wdata   - signed write data
//   cfg_commit  - request shadow -> active transfer at the next strobe
//   cfg_pending - commit requested, not yet applied
// Revision    : 1.0 - initial release
// ============================================================================
interface ns_mode_controller_if;
    import ns_ctrl_pkg::*;

    logic                     cfg_we;
    logic                     cfg_addr;
    logic signed [GAIN_W-1:0] cfg_wdata;
    logic                     cfg_commit;
    logic                     cfg_pending;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_wdata,
        output cfg_commit,
        input  cfg_pending
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata,
        input  cfg_commit,
        output cfg_pending
    );

endinterface
`default_nettype wire

// File: rtl/ns_mode_controller_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : ns_strobe_gen
// Description : Free-running divide-by-DIV counter. enable_3M is high for one
//               clock whenever the counter sits at its terminal count.
//   CLK_24M   - clock
//   reset     - asynchronous, active-low reset
//   enable_3M - one-cycle strobe every DIV clocks
// Revision    : 1.0 - initial release
// ============================================================================
module ns_strobe_gen #(
    parameter int DIV = 8
) (
    input  wire  CLK_24M,
    input  wire  reset,
    output logic enable_3M
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DIV - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Decoded straight from the counter so the strobe lines up with the
    // cycle in which the counter reads DIV-1.
    assign enable_3M = (r_cnt == CNT_W'(DIV - 1));

endmodule
`default_nettype wire

// File: rtl/ns_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : ns_mode_controller
// Description : Sequencer and configuration controller for the fifth-order
//               noise shaper. Generates the 3 MHz sample strobe, selects
//               HSNR/HDR feedback with attack/release hysteresis, and holds
//               the HSNR gains behind a shadow/commit register pair.
//   CLK_24M              - sole clock
//   reset                - asynchronous, active-low reset
//   data_i               - signed shaper input, sampled on strobe cycles
//   cfg                  - config bus (slave side)
//   enable_3M            - one-cycle strobe every 8th clock
//   alpha                - 0 = HSNR, 1 = HDR
//   HSNR_offset_gain_pos - active positive gain
//   HSNR_offset_gain_neg - active negative gain
//   mode_change          - one-cycle pulse when alpha toggles
// Revision    : 1.0 - initial release
// ============================================================================
module ns_mode_controller
    import ns_ctrl_pkg::*;
#(
    parameter int NR_SIG_PATH_BITS = 21,
    parameter int ATTACK_THR       = 768,
    parameter int RELEASE_THR      = 256,
    parameter int ATTACK_SAMPLES   = 2,
    parameter int RELEASE_SAMPLES  = 4096
) (
    input  wire                       CLK_24M,
    input  wire                       reset,
    input  wire signed [DATA_W-1:0]   data_i,
    ns_mode_controller_if.slave       cfg,
    output logic                      enable_3M,
    output logic                      alpha,
    output logic signed [GAIN_W-1:0]  HSNR_offset_gain_pos,
    output logic signed [GAIN_W-1:0]  HSNR_offset_gain_neg,
    output logic                      mode_change
);

    localparam int ATK_W = $clog2(ATTACK_SAMPLES + 1);
    localparam int REL_W = $clog2(RELEASE_SAMPLES + 1);

    localparam logic [ATK_W-1:0] c_ATK_MAX = {ATK_W{1'b1}};
    localparam logic [REL_W-1:0] c_REL_MAX = {REL_W{1'b1}};

    localparam logic signed [GAIN_W-1:0] c_DEF_POS = default_gain_pos(NR_SIG_PATH_BITS);
    localparam logic signed [GAIN_W-1:0] c_DEF_NEG = default_gain_neg(NR_SIG_PATH_BITS);

    logic              w_strobe;
    logic [DATA_W-1:0] w_mag;
    logic              w_loud;
    logic              w_quiet;

    ns_mode_t          r_state;
    logic [ATK_W-1:0]  r_atk_cnt;
    logic [REL_W-1:0]  r_rel_cnt;
    logic              r_mode_change;

    logic signed [GAIN_W-1:0] r_shadow_pos;
    logic signed [GAIN_W-1:0] r_shadow_neg;
    logic signed [GAIN_W-1:0] r_active_pos;
    logic signed [GAIN_W-1:0] r_active_neg;
    logic                     r_cfg_pending;

    // ------------------------------------------------------------------
    // Sample strobe
    // ------------------------------------------------------------------
    ns_strobe_gen #(
        .DIV       (STROBE_DIV)
    ) u_strobe_gen (
        .CLK_24M   (CLK_24M),
        .reset     (reset),
        .enable_3M (w_strobe)
    );

    // ------------------------------------------------------------------
    // Magnitude: treated as unsigned so -1024 becomes 1024 rather than
    // wrapping back to a negative value.
    // ------------------------------------------------------------------
    assign w_mag   = data_i[DATA_W-1] ? $unsigned(-data_i) : $unsigned(data_i);
    assign w_loud  = (int'(w_mag) >= ATTACK_THR);
    assign w_quiet = (int'(w_mag) <  RELEASE_THR);

    // ------------------------------------------------------------------
    // Mode FSM with hysteresis counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            r_state       <= S_HDR;
            r_atk_cnt     <= '0;
            r_rel_cnt     <= '0;
            r_mode_change <= 1'b0;
        end else begin
            r_mode_change <= 1'b0;
            if (w_strobe) begin
                case (r_state)
                    S_HSNR: begin
                        if (w_loud) begin
                            if (int'(r_atk_cnt) + 1 == ATTACK_SAMPLES) begin
                                r_state       <= S_HDR;
                                r_atk_cnt     <= '0;
                                r_rel_cnt     <= '0;
                                r_mode_change <= 1'b1;
                            end else if (r_atk_cnt != c_ATK_MAX) begin
                                r_atk_cnt <= r_atk_cnt + ATK_W'(1);
                            end
                        end else begin
                            r_atk_cnt <= '0;
                        end
                    end
                    S_HDR: begin
                        if (w_quiet) begin
                            if (int'(r_rel_cnt) + 1 == RELEASE_SAMPLES) begin
                                r_state       <= S_HSNR;
                                r_atk_cnt     <= '0;
                                r_rel_cnt     <= '0;
                                r_mode_change <= 1'b1;
                            end else if (r_rel_cnt != c_REL_MAX) begin
                                r_rel_cnt <= r_rel_cnt + REL_W'(1);
                            end
                        end else begin
                            r_rel_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_HDR;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Config registers. Writes land in the shadows on any cycle; the
    // active pair only moves on a strobe edge that already sees pending,
    // so a commit raised on a strobe cycle waits for the next strobe and
    // the datapath never sees a half-updated gain pair.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            r_shadow_pos  <= c_DEF_POS;
            r_shadow_neg  <= c_DEF_NEG;
            r_active_pos  <= c_DEF_POS;
            r_active_neg  <= c_DEF_NEG;
            r_cfg_pending <= 1'b0;
        end else begin
            if (cfg.cfg_we) begin
                if (cfg.cfg_addr == CFG_GAIN_NEG) begin
                    r_shadow_neg <= cfg.cfg_wdata;
                end else begin
                    r_shadow_pos <= cfg.cfg_wdata;
                end
            end

            if (w_strobe && r_cfg_pending) begin
                r_active_pos  <= r_shadow_pos;
                r_active_neg  <= r_shadow_neg;
                r_cfg_pending <= 1'b0;
            end else if (cfg.cfg_commit) begin
                r_cfg_pending <= 1'b1;
            end
        end
    end

    assign enable_3M            = w_strobe;
    assign alpha                = (r_state == S_HDR);
    assign mode_change          = r_mode_change;
    assign HSNR_offset_gain_pos = r_active_pos;
    assign HSNR_offset_gain_neg = r_active_neg;
    assign cfg.cfg_pending      = r_cfg_pending;

endmodule
`default_nettype wire

// File: tb/tb_ns_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ns_mode_controller
// Description : Directed self-checking bench for ns_mode_controller with
//               RELEASE_SAMPLES = 4. Inputs change and outputs are sampled
//               1 ns after each rising edge; 'phase' tracks the expected
//               strobe counter independently of the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ns_mode_controller;
    import ns_ctrl_pkg::*;

    localparam logic signed [23:0] c_DEF_POS = 24'sh200000;   // +2097152
    localparam logic signed [23:0] c_DEF_NEG = 24'shE00000;   // -2097152

    logic                     CLK_24M;
    logic                     reset;
    logic signed [10:0]       data_i;
    logic                     enable_3M;
    logic                     alpha;
    logic signed [23:0]       HSNR_offset_gain_pos;
    logic signed [23:0]       HSNR_offset_gain_neg;
    logic                     mode_change;

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    ns_mode_controller_if cfg_bus ();

    ns_mode_controller #(
        .RELEASE_SAMPLES      (4)
    ) dut (
        .CLK_24M              (CLK_24M),
        .reset                (reset),
        .data_i               (data_i),
        .cfg                  (cfg_bus),
        .enable_3M            (enable_3M),
        .alpha                (alpha),
        .HSNR_offset_gain_pos (HSNR_offset_gain_pos),
        .HSNR_offset_gain_neg (HSNR_offset_gain_neg),
        .mode_change          (mode_change)
    );

    initial CLK_24M = 1'b0;
    always #5 CLK_24M = ~CLK_24M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_24M);
        #1;
        phase = (phase + 1) % 8;
    endtask

    // Advance through the next strobe edge (ends at phase 0)
    task automatic next_strobe();
        do tick(); while (phase != 0);
    endtask

    task automatic to_phase(input int p);
        while (phase != p) tick();
    endtask

    task automatic cfg_write(input logic addr, input logic signed [23:0] d);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_addr  = addr;
        cfg_bus.cfg_wdata = d;
        tick();
        cfg_bus.cfg_we    = 1'b0;
    endtask

    task automatic commit();
        cfg_bus.cfg_commit = 1'b1;
        tick();
        cfg_bus.cfg_commit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b0;
        data_i             = 11'sd300;
        cfg_bus.cfg_we     = 1'b0;
        cfg_bus.cfg_addr   = 1'b0;
        cfg_bus.cfg_wdata  = '0;
        cfg_bus.cfg_commit = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_enable", enable_3M, 0);
        chk("rst_alpha", alpha, 1);
        chk("rst_mode_change", mode_change, 0);
        chk("rst_pending", cfg_bus.cfg_pending, 0);
        chk("rst_pos", HSNR_offset_gain_pos, c_DEF_POS);
        chk("rst_neg", HSNR_offset_gain_neg, c_DEF_NEG);

        // ---------------- strobe after release ----------------
        reset = 1'b1;
        phase = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk($sformatf("strobe_clk%0d", k), enable_3M, (k % 8 == 7) ? 1 : 0);
        end
        chk("hold_alpha", alpha, 1);

        // ---------------- HDR -> HSNR release ----------------
        data_i = 11'sd100;
        next_strobe(); next_strobe(); next_strobe();
        chk("rel_before_alpha", alpha, 1);
        next_strobe();
        chk("rel_alpha", alpha, 0);
        chk("rel_mode_change", mode_change, 1);
        tick();
        chk("rel_mode_change_one", mode_change, 0);

        // ---------------- HSNR -> HDR attack ----------------
        data_i = 11'sd767;
        next_strobe();
        chk("atk_767", alpha, 0);
        data_i = -11'sd1024;
        next_strobe();
        data_i = 11'sd767;
        next_strobe();
        chk("atk_broken", alpha, 0);
        data_i = -11'sd1024;
        next_strobe();
        chk("atk_first", alpha, 0);
        next_strobe();
        chk("atk_alpha", alpha, 1);
        chk("atk_mode_change", mode_change, 1);

        // ---------------- delayed release ----------------
        data_i = 11'sd100;
        next_strobe(); next_strobe();
        data_i = 11'sd300;
        next_strobe();
        data_i = 11'sd100;
        next_strobe(); next_strobe(); next_strobe();
        chk("delay_hold", alpha, 1);
        next_strobe();
        chk("delay_alpha", alpha, 0);
        chk("delay_mode_change", mode_change, 1);
        data_i = 11'sd300;

        // ---------------- config commit at counter 3 ----------------
        tick();
        cfg_write(CFG_GAIN_POS, 24'sh100000);
        cfg_write(CFG_GAIN_NEG, 24'shF00000);
        commit();
        chk("cmt_pending_rise", cfg_bus.cfg_pending, 1);
        chk("cmt_pos_hold", HSNR_offset_gain_pos, c_DEF_POS);
        to_phase(7);
        chk("cmt_pending_pre", cfg_bus.cfg_pending, 1);
        tick();
        chk("cmt_pending_clr", cfg_bus.cfg_pending, 0);
        chk("cmt_pos", HSNR_offset_gain_pos, 24'sh100000);
        chk("cmt_neg", HSNR_offset_gain_neg, 24'shF00000);

        // ---------------- commit on a strobe cycle ----------------
        tick();
        cfg_write(CFG_GAIN_POS, 24'sh0ABCDE);
        to_phase(7);
        commit();
        chk("stb_cmt_pending", cfg_bus.cfg_pending, 1);
        chk("stb_cmt_pos_hold", HSNR_offset_gain_pos, 24'sh100000);
        next_strobe();
        chk("stb_cmt_pos", HSNR_offset_gain_pos, 24'sh0ABCDE);
        chk("stb_cmt_pending_clr", cfg_bus.cfg_pending, 0);

        // ---------------- write+commit together, then write while pending ----------------
        tick();
        cfg_bus.cfg_we     = 1'b1;
        cfg_bus.cfg_addr   = CFG_GAIN_NEG;
        cfg_bus.cfg_wdata  = 24'sh123456;
        cfg_bus.cfg_commit = 1'b1;
        tick();
        cfg_bus.cfg_we     = 1'b0;
        cfg_bus.cfg_commit = 1'b0;
        to_phase(4);
        cfg_write(CFG_GAIN_POS, 24'sh000123);
        chk("wp_pending", cfg_bus.cfg_pending, 1);
        next_strobe();
        chk("wp_pos", HSNR_offset_gain_pos, 24'sh000123);
        chk("wp_neg", HSNR_offset_gain_neg, 24'sh123456);

        // ---------------- reset mid-operation ----------------
        data_i = -11'sd1024;
        next_strobe(); next_strobe();
        chk("mid_hdr", alpha, 1);
        data_i = 11'sd100;
        next_strobe(); next_strobe(); next_strobe();
        cfg_write(CFG_GAIN_POS, 24'sh055555);
        commit();
        to_phase(5);
        chk("mid_pending", cfg_bus.cfg_pending, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_enable", enable_3M, 0);
        chk("mid_rst_alpha", alpha, 1);
        chk("mid_rst_mode_change", mode_change, 0);
        chk("mid_rst_pending", cfg_bus.cfg_pending, 0);
        chk("mid_rst_pos", HSNR_offset_gain_pos, c_DEF_POS);
        chk("mid_rst_neg", HSNR_offset_gain_neg, c_DEF_NEG);
        tick(); tick();
        reset = 1'b1;
        phase = 0;
        repeat (6) tick();
        chk("post_rst_no_strobe", enable_3M, 0);
        tick();
        chk("post_rst_strobe", enable_3M, 1);
        tick();
        chk("post_rst_alpha1", alpha, 1);
        tick();
        commit();
        next_strobe();
        chk("post_rst_pos", HSNR_offset_gain_pos, c_DEF_POS);
        chk("post_rst_neg", HSNR_offset_gain_neg, c_DEF_NEG);
        chk("post_rst_pending", cfg_bus.cfg_pending, 0);
        next_strobe();
        chk("post_rst_alpha3", alpha, 1);
        next_strobe();
        chk("post_rst_release", alpha, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ns_mode_controller.md
# ns_mode_controller

Sequencer and configuration controller for the fifth-order noise shaper.
- Generates the 3 MHz sample strobe from the 24 MHz clock.
- Drives `alpha`, switching between HSNR (`alpha`=0) and HDR (`alpha`=1) feedback from the input level, with attack/release hysteresis.
- Holds the HSNR feedback gains, loaded through a shadow-register write port and applied atomically on a sample boundary.
- Sits between the register/config bus and the noise-shaper datapath.

## Interface
Parameters:
- `NR_SIG_PATH_BITS`, default 21: signal path width; sets the default gains ±2^NR_SIG_PATH_BITS.
- `ATTACK_THR`, default 768: |data_i| at or above this counts as loud.
- `RELEASE_THR`, default 256: |data_i| strictly below this counts as quiet.
- `ATTACK_SAMPLES`, default 2: consecutive loud samples needed to enter HDR.
- `RELEASE_SAMPLES`, default 4096: consecutive quiet samples needed to return to HSNR.

Ports:
- `CLK_24M`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `data_i`  in  11 signed  shaper input sample; sampled on strobe cycles only.
- `cfg_we`  in  1  shadow register write strobe.
- `cfg_addr`  in  1  0 = positive gain, 1 = negative gain.
- `cfg_wdata`  in  24 signed  write data.
- `cfg_commit`  in  1  request to transfer shadow to active at the next strobe.
- `enable_3M`  out  1  one-cycle strobe, every 8th clock.
- `alpha`  out  1  0 = HSNR, 1 = HDR.
- `HSNR_offset_gain_pos`  out  24 signed  active positive gain.
- `HSNR_offset_gain_neg`  out  24 signed  active negative gain.
- `cfg_pending`  out  1  commit requested, not yet applied.
- `mode_change`  out  1  one-cycle pulse when `alpha` toggles.

## Operation
Strobe:
- 3-bit counter runs 0..7 and wraps.
- `enable_3M` is combinationally high when counter == 7. All state below updates only on strobe cycles unless stated.

Magnitude:
- mag = |data_i|, 11-bit unsigned. -1024 maps to 1024; no wrap.

Mode FSM, states S_HDR and S_HSNR; reset state S_HDR:
- S_HSNR, on strobe:
  - mag ≥ ATTACK_THR: atk_cnt increments. Otherwise atk_cnt clears.
  - atk_cnt+1 == ATTACK_SAMPLES: go to S_HDR and clear both counters.
- S_HDR, on strobe:
  - mag < RELEASE_THR: rel_cnt increments. Otherwise rel_cnt clears.
  - rel_cnt+1 == RELEASE_SAMPLES: go to S_HSNR and clear both counters.
- Both counters saturate and never wrap. Counter widths are $clog2(N+1).
- `alpha` is the registered state: 1 in S_HDR.
- `mode_change` is registered and high for exactly one cycle, the same cycle the new `alpha` first appears.

Config:
- `cfg_we` writes shadow[cfg_addr] on any cycle, independent of the strobe.
- `cfg_commit` sets `cfg_pending`.
- A strobe cycle whose clock edge sees `cfg_pending`=1 (already registered) copies both shadows to the active gains and clears `cfg_pending`.
- Simultaneous events:
  - Commit in the same cycle as a strobe is applied at the following strobe.
  - Write and commit in the same cycle: the write is included.
  - A write while pending, before the apply edge, is included.
  - Commit while pending has no additional effect.

## Timing
Reset values:
- counter 0, `enable_3M` 0, `alpha` 1, `mode_change` 0, `cfg_pending` 0.
- Active and shadow gains: pos = +2^NR_SIG_PATH_BITS, neg = -2^NR_SIG_PATH_BITS.

Latency:
- First `enable_3M` is on the 8th rising edge after reset deasserts (counter 7). Period is exactly 8 clocks.
- `alpha` and the gains change on the strobe edge, so the datapath sees them from the next sample onward. Outputs are stable for 8 clocks between strobes.
- `cfg_pending` rises one clock after `cfg_commit`.

Reset mid-operation:
- Asserting reset forces all outputs to reset values immediately.
- Pending commits and partial counts are lost; shadows return to defaults.

## Structure
- Package `ns_ctrl_pkg`:
  - mode enum {S_HSNR, S_HDR}.
  - cfg address constants CFG_GAIN_POS=0, CFG_GAIN_NEG=1.
  - strobe divide constant 8.
  - default-gain function of NR_SIG_PATH_BITS.
- Sub-module `ns_strobe_gen`: divide-by-8 counter producing `enable_3M`.
- FSM, hysteresis counters and config registers stay in the top level.

## Test plan
- Reset release:
  - Required: `enable_3M` pulses at clocks 8, 16, 24.
  - Required: `alpha`=1, gains = +2097152 / -2097152.
- HDR to HSNR release: data_i=100 held; RELEASE_SAMPLES=4 for the bench.
  - Required: `alpha` falls on the 4th strobe edge; `mode_change` pulses once.
  - data_i=300 on sample 3 instead: rel_cnt resets and the release is delayed by 3 samples.
- HSNR to HDR attack: in HSNR, data_i=-1024 on two consecutive strobes.
  - Required: `alpha`=1 after the 2nd strobe edge.
  - data_i=767 on either strobe: no switch.
- Config commit: write pos=0x100000, neg=0xF00000, commit at counter=3.
  - Required: gains change at the next strobe; `cfg_pending` 1→0 on that edge.
  - Commit on a strobe cycle: applied one strobe later.
- Write during pending: commit, then write pos=0x000123 before the strobe.
  - Required: the applied pos is 0x000123.
- Reset mid-operation: assert reset at counter=5 with pending=1 and rel_cnt=3.
  - Required: all outputs return to reset values; after release, the first strobe is 8 clocks later and gains are the defaults.
